// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, 3-sample majority bit decoder,
// optional parity, 1/2 stop bits, break detection and a show-ahead receive FIFO.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 65_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 overrun,
    output logic                 break_det
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int MID  = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int IW   = $clog2(DATA_BITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int WW   = DATA_BITS + 2;

    localparam logic [CW-1:0]   C_S0     = CW'(MID - 1);
    localparam logic [CW-1:0]   C_S1     = CW'(MID);
    localparam logic [CW-1:0]   C_DEC    = CW'(MID + 1);
    localparam logic [CW-1:0]   C_END    = CW'(CPB - 1);
    localparam logic [IW-1:0]   LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);
    localparam logic            ODD_P    = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_s;
    logic [CW-1:0]        cnt;
    logic [1:0]           samp;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, perr, frame_err_r, stop_one;

    logic                 maj, at_dec, at_end, last_stop, fin, brk, push, ferr_n;

    assign maj       = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign at_dec    = (cnt == C_DEC);
    assign at_end    = (cnt == C_END);
    assign last_stop = (STOP_BITS == 1) || stop_idx;
    assign fin       = (state == S_STOP) && at_dec && last_stop;
    assign ferr_n    = frame_err_r | ~maj;
    // A break is a frame whose every bit, stop bits included, decoded as 0.
    assign brk       = fin && (shreg == '0) && !par_bit && !stop_one && !maj;
    assign push      = fin && !brk;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (!rx_s) state_n = S_START;
            S_START:    if (at_dec && maj) state_n = S_IDLE;
                        else if (at_end) state_n = S_DATA;
            S_DATA:     if (at_end && bit_idx == LAST_IDX)
                            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:   if (at_end) state_n = S_STOP;
            S_STOP:     if (fin) state_n = brk ? S_BRK_WAIT : S_IDLE;
            S_BRK_WAIT: if (rx_s) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            cnt         <= '0;
            samp        <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            perr        <= 1'b0;
            frame_err_r <= 1'b0;
            stop_one    <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            break_det <= brk;
            if (state_n != state || at_end || state == S_IDLE || state == S_BRK_WAIT)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (cnt == C_S0) samp[0] <= rx_s;
            if (cnt == C_S1) samp[1] <= rx_s;
            case (state)
                S_IDLE: begin
                    bit_idx     <= '0;
                    stop_idx    <= 1'b0;
                    shreg       <= '0;
                    par_bit     <= 1'b0;
                    perr        <= 1'b0;
                    frame_err_r <= 1'b0;
                    stop_one    <= 1'b0;
                end
                S_DATA: begin
                    if (at_dec) shreg[bit_idx] <= maj;
                    if (at_end) bit_idx <= bit_idx + 1'b1;
                end
                S_PARITY: if (at_dec) begin
                    par_bit <= maj;
                    perr    <= ((^shreg) ^ maj) != ODD_P;
                end
                S_STOP: begin
                    if (at_dec && !maj) frame_err_r <= 1'b1;
                    if (at_dec && maj)  stop_one    <= 1'b1;
                    if (at_end)         stop_idx    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Receive FIFO; a full FIFO still accepts a word when the head is popped in the same cycle.
    logic [WW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            full, pop, wr_en;

    assign full  = (count == FULL_CNT);
    assign pop   = m_valid && m_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {perr, ferr_n, shreg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign m_valid = (count != '0);
    assign {m_parity_err, m_frame_err, m_data} = m_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 receiver and an 8E2 receiver, each with
// its own serial line, checked against a frame-level model of the expected words.
module tb_uart_rx_cfg;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] md0, md1;
    logic mv0, mv1, pe0, pe1, fe0, fe1, ov0, ov1, bk0, bk1;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .m_data(md0), .m_valid(mv0), .m_ready(rdy0),
        .m_parity_err(pe0), .m_frame_err(fe0), .overrun(ov0), .break_det(bk0));

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .m_data(md1), .m_valid(mv1), .m_ready(rdy1),
        .m_parity_err(pe1), .m_frame_err(fe1), .overrun(ov1), .break_det(bk1));

    int n_cmp = 0, n_err = 0;
    logic [9:0] q0[$], q1[$];
    int ovr_cnt[2], brk_cnt[2], exp_ovr[2], exp_brk[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int qsz(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic pop_chk(input int u, input logic [9:0] w);
        logic [9:0] e;
        if (qsz(u) == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word_u%0d: got %0h expected none", u, w);
        end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("word_u%0d", u), {22'd0, w}, {22'd0, e});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mv0 && rdy0) pop_chk(0, {pe0, fe0, md0});
            if (mv1 && rdy1) pop_chk(1, {pe1, fe1, md1});
            if (ov0) ovr_cnt[0]++;
            if (ov1) ovr_cnt[1]++;
            if (bk0) brk_cnt[0]++;
            if (bk1) brk_cnt[1]++;
        end
    end

    task automatic set_rx(input int u, input logic b);
        if (u == 0) rx0 = b;
        else        rx1 = b;
    endtask

    task automatic drive_bit(input int u, input logic b);
        @(negedge clk);
        set_rx(u, b);
        repeat (CPB - 1) @(negedge clk);
    endtask

    // Model: a frame is a break if every bit is 0; otherwise the word is expected
    // unless the FIFO already holds DEPTH unread words, in which case it overruns.
    task automatic send_frame(input int u, input logic [7:0] d, input logic pbit,
                              input logic [1:0] stp, input bit chk_lat);
        bit has_par, perr, ferr, brk;
        int nst;
        has_par = (u == 1);
        nst     = (u == 1) ? 2 : 1;
        perr    = has_par ? ((^d ^ pbit) != 1'b0) : 1'b0;
        ferr    = !stp[0] || (nst == 2 && !stp[1]);
        brk     = (d == 8'h00) && (!has_par || !pbit) && !stp[0] && (nst == 1 || !stp[1]);
        if (brk) exp_brk[u]++;
        else if (qsz(u) >= DEPTH) exp_ovr[u]++;
        else if (u == 0) q0.push_back({perr, ferr, d});
        else q1.push_back({perr, ferr, d});

        drive_bit(u, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(u, d[i]);
        if (has_par) drive_bit(u, pbit);
        if (chk_lat) begin
            @(negedge clk);
            set_rx(u, stp[0]);
            repeat (12) @(negedge clk);
            chk("valid_before_decision", {31'd0, mv0}, 32'd0);
            @(negedge clk);
            chk("valid_after_decision", {31'd0, mv0}, 32'd1);
            repeat (CPB - 14) @(negedge clk);
        end else begin
            drive_bit(u, stp[0]);
        end
        if (nst == 2) drive_bit(u, stp[1]);
        @(negedge clk);
        set_rx(u, 1'b1);
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        logic pb;
        logic [1:0] st;
        int u, t;
        for (int i = 0; i < 2; i++) begin
            ovr_cnt[i] = 0; brk_cnt[i] = 0; exp_ovr[i] = 0; exp_brk[i] = 0;
        end

        repeat (5) @(negedge clk);
        chk("rst_valid", {30'd0, mv1, mv0}, 32'd0);
        chk("rst_data0", {24'd0, md0}, 32'd0);
        chk("rst_data1", {24'd0, md1}, 32'd0);
        chk("rst_errs", {28'd0, pe1, fe1, pe0, fe0}, 32'd0);
        chk("rst_pulses", {28'd0, ov1, bk1, ov0, bk0}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 0xA5 with latency check, held until ready
        rdy0 = 1'b0;
        send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b1);
        rdy0 = 1'b1;
        repeat (4) @(negedge clk);

        // 8E2 parity cases and 8N1 framing error
        send_frame(1, 8'h07, 1'b0, 2'b11, 1'b0);
        send_frame(1, 8'h07, 1'b1, 2'b11, 1'b0);
        send_frame(1, 8'h3C, 1'b0, 2'b01, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 2'b10, 1'b0);

        // start-bit glitch is rejected
        @(negedge clk);
        rx0 = 1'b0;
        repeat (3) @(negedge clk);
        rx0 = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_no_word", {31'd0, mv0}, 32'd0);

        // overrun on the fifth word, then drain in order
        rdy0 = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 2'b11, 1'b0);
        chk("ovr_count", ovr_cnt[0], exp_ovr[0]);
        chk("ovr_fifo_full_valid", {31'd0, mv0}, 32'd1);
        rdy0 = 1'b1;
        repeat (10) @(negedge clk);
        chk("ovr_drained", qsz(0), 0);

        // long break, then a normal byte
        exp_brk[0]++;
        @(negedge clk);
        rx0 = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        rx0 = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("break_u0", brk_cnt[0], exp_brk[0]);
        send_frame(0, 8'h55, 1'b0, 2'b11, 1'b0);
        send_frame(1, 8'h00, 1'b0, 2'b00, 1'b0);
        chk("break_u1", brk_cnt[1], exp_brk[1]);

        // reset in the middle of data bit 3 aborts the frame
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        @(negedge clk);
        rx0 = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        chk("rst_abort_no_word", {31'd0, mv0}, 32'd0);
        send_frame(0, 8'h55, 1'b0, 2'b11, 1'b0);

        // randomized frames on both receivers
        for (int n = 0; n < 40; n++) begin
            u  = $urandom_range(0, 1);
            d  = 8'($urandom);
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            send_frame(u, d, pb, st, 1'b0);
        end

        t = 0;
        while ((qsz(0) != 0 || qsz(1) != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("queues_drained", qsz(0) + qsz(1), 0);
        chk("final_ovr_u0", ovr_cnt[0], exp_ovr[0]);
        chk("final_ovr_u1", ovr_cnt[1], exp_ovr[1]);
        chk("final_brk_u0", brk_cnt[0], exp_brk[0]);
        chk("final_brk_u1", brk_cnt[1], exp_brk[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
